issue_queue: RTL and testbench

- Out-of-order issue queue directly downstream of the rename stage.
- Each cycle it accepts one renamed instruction (rinstr_t) and tracks operand readiness using physical-register wakeup broadcasts (p_reg_t).
- It issues the oldest instruction whose operands are all ready to the execute stage over a valid/ready handshake.
- It squashes speculative entries on a branch mispredict and backpressures rename through iq_full_o.

---
 rtl/issue_queue_pkg.sv | 52 +++++
 rtl/issue_queue_if.sv | 28 ++
 rtl/issue_queue_select.sv | 27 ++
 rtl/issue_queue.sv | 152 +++++++++++++++
 tb/tb_issue_queue.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared rename/issue types: renamed instruction, physical-register wakeup,
// branch resolution and the issue-queue entry wrapper.
package issue_queue_pkg;

   localparam int PREG_W = 6;   // 64 physical registers
   localparam int OP_W   = 4;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] idx;
   } p_reg_t;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] idx;
      logic              ready;
   } src_t;

   typedef struct packed {
      logic valid;
      logic hit;
   } br_result_t;

   typedef struct packed {
      logic              valid;
      logic              is_branch;
      logic [OP_W-1:0]   op;
      logic [PREG_W-1:0] rd;
      src_t              rs1;
      src_t              rs2;
   } rinstr_t;

   typedef struct packed {
      rinstr_t instr;
      logic    spec;
   } iq_entry_t;

   // True when a wakeup broadcast names this (valid) source operand.
   function automatic logic wake_hit(src_t src, p_reg_t wakeup);
      return wakeup.valid && src.valid && (src.idx == wakeup.idx);
   endfunction

   // Readiness of a source as it enters the queue: unused sources count as
   // ready, and a same-cycle wakeup is captured so it is not missed.
   function automatic src_t src_at_insert(src_t src, p_reg_t wakeup);
      src_t s;
      s = src;
      s.ready = src.ready || !src.valid || wake_hit(src, wakeup);
      return s;
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Bundle between rename/execute and the issue queue.
interface issue_queue_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   import issue_queue_pkg::*;

   rinstr_t          rinstr_i;
   br_result_t       br_result_i;
   p_reg_t           wakeup_i;
   rinstr_t          issue_o;
   logic             issue_ready_i;
   logic             iq_full_o;
   logic [CNT_W-1:0] count_o;

   // Rename, branch unit, wakeup bus and execute drive the queue
   modport master (
      output rinstr_i, br_result_i, wakeup_i, issue_ready_i,
      input  issue_o, iq_full_o, count_o
   );

   // The queue itself
   modport slave (
      input  rinstr_i, br_result_i, wakeup_i, issue_ready_i,
      output issue_o, iq_full_o, count_o
   );

endinterface

// File: rtl/issue_queue_select.sv
// Oldest-ready picker: lowest set bit of the request vector wins.
module iq_select #(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] ready,
   output logic [DEPTH-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the youngest slot down so the oldest requester is written last
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue. Slot 0 is always the oldest entry and
// valid entries are contiguous; pops and squashes compact the array in place.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   issue_queue_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   iq_entry_t        entries_reg  [DEPTH];
   iq_entry_t        entries_next [DEPTH];
   logic [CNT_W-1:0] count_reg, count_next;
   logic             spec_active_reg, spec_active_next;
   // A stalled issue keeps pointing at the same entry even if an older one
   // becomes ready meanwhile, so issue_o stays stable under backpressure.
   logic             hold_reg, hold_next;
   logic [IDX_W-1:0] hold_idx_reg, hold_idx_next;

   logic [DEPTH-1:0] eligible, pick_oh, sel_oh, keep;
   logic [IDX_W-1:0] pick_idx, sel_idx;
   logic             pick_any, sel_any;
   iq_entry_t        sel_entry, new_entry;
   logic             full, mispredict, br_hit, issue_valid, pop, insert;

   assign full       = (count_reg == CNT_W'(DEPTH));
   assign mispredict = bus.br_result_i.valid && !bus.br_result_i.hit;
   assign br_hit     = bus.br_result_i.valid && bus.br_result_i.hit;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign eligible[gi] = entries_reg[gi].instr.valid &&
                               entries_reg[gi].instr.rs1.ready &&
                               entries_reg[gi].instr.rs2.ready;
         assign sel_oh[gi]   = hold_reg ? (hold_idx_reg == IDX_W'(gi)) : pick_oh[gi];
         assign keep[gi]     = entries_reg[gi].instr.valid &&
                               !(pop && sel_oh[gi]) &&
                               !(mispredict && entries_reg[gi].spec);
      end
   endgenerate

   iq_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_select (
      .ready (eligible),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign sel_idx   = hold_reg ? hold_idx_reg : pick_idx;
   assign sel_any   = hold_reg || pick_any;
   assign sel_entry = entries_reg[sel_idx];

   // A spec entry being squashed this cycle must not leave the queue as issued
   assign issue_valid = sel_any && !(mispredict && sel_entry.spec);
   assign pop         = issue_valid && bus.issue_ready_i;
   assign insert      = bus.rinstr_i.valid && !full && !mispredict;

   assign bus.iq_full_o = full;
   assign bus.count_o   = count_reg;

   // Present the selected entry with its valid qualified by the squash gate
   always_comb begin
      bus.issue_o       = sel_entry.instr;
      bus.issue_o.valid = issue_valid;
   end

   // Build the entry for an incoming instruction, including wakeup bypass
   always_comb begin
      new_entry           = '0;
      new_entry.instr     = bus.rinstr_i;
      new_entry.instr.rs1 = src_at_insert(bus.rinstr_i.rs1, bus.wakeup_i);
      new_entry.instr.rs2 = src_at_insert(bus.rinstr_i.rs2, bus.wakeup_i);
      // The branch itself is never speculative; a resolving branch clears it
      new_entry.spec      = spec_active_reg && !bus.br_result_i.valid &&
                            !bus.rinstr_i.is_branch;
   end

   // Compact survivors toward slot 0, apply wakeups, then append the insert
   always_comb begin
      iq_entry_t        e;
      logic [CNT_W-1:0] wr;
      for (int i = 0; i < DEPTH; i++) begin
         entries_next[i] = '0;
      end
      e             = '0;
      wr            = '0;
      hold_idx_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         e = entries_reg[i];
         e.instr.rs1.ready = e.instr.rs1.ready || wake_hit(e.instr.rs1, bus.wakeup_i);
         e.instr.rs2.ready = e.instr.rs2.ready || wake_hit(e.instr.rs2, bus.wakeup_i);
         if (br_hit) begin
            e.spec = 1'b0;
         end
         if (keep[i]) begin
            entries_next[wr[IDX_W-1:0]] = e;
            if (sel_oh[i]) begin
               hold_idx_next = wr[IDX_W-1:0];
            end
            wr = wr + CNT_W'(1);
         end
      end
      if (insert) begin
         entries_next[wr[IDX_W-1:0]] = new_entry;
         wr = wr + CNT_W'(1);
      end
      count_next = wr;
   end

   // Speculation window opens on an accepted branch, closes on any resolution
   always_comb begin
      spec_active_next = spec_active_reg;
      if (bus.br_result_i.valid) begin
         spec_active_next = 1'b0;
      end
      if (insert && bus.rinstr_i.is_branch) begin
         spec_active_next = 1'b1;
      end
      hold_next = issue_valid && !bus.issue_ready_i;
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_reg[i] <= '0;
         end
         count_reg       <= '0;
         spec_active_reg <= 1'b0;
         hold_reg        <= 1'b0;
         hold_idx_reg    <= '0;
      end else begin
         entries_reg     <= entries_next;
         count_reg       <= count_next;
         spec_active_reg <= spec_active_next;
         hold_reg        <= hold_next;
         hold_idx_reg    <= hold_idx_next;
      end
   end

   // Occupancy must stay within [0, DEPTH]
   assert property (@(posedge clk_i) disable iff (rst_i) count_next <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_issue_queue.sv
// Testbench for issue_queue: directed table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int NV    = 30;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   issue_queue_if #(.DEPTH(DEPTH)) bus ();

   issue_queue #(.DEPTH(DEPTH)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   typedef struct {
      rinstr_t instr;
      logic    spec;
      int      tag;
   } m_ent_t;

   m_ent_t m_q[$];
   logic   m_spec_active;
   int     m_hold_tag;
   int     m_next_tag;

   typedef struct {
      int in_v, is_br, rd, s1v, s1;
      int br_v, br_hit, wk_v, wk, rdy;
      int exp_iv, exp_rd, exp_cnt;
   } vec_t;

   vec_t vecs[NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic rinstr_t mk(logic v, logic br, logic [5:0] rd,
                                  logic s1v, logic [5:0] s1, logic s1r,
                                  logic s2v, logic [5:0] s2, logic s2r);
      rinstr_t r;
      r.valid     = v;
      r.is_branch = br;
      r.op        = rd[3:0];
      r.rd        = rd;
      r.rs1.valid = s1v;
      r.rs1.idx   = s1;
      r.rs1.ready = s1r;
      r.rs2.valid = s2v;
      r.rs2.idx   = s2;
      r.rs2.ready = s2r;
      return r;
   endfunction

   function automatic vec_t v(int in_v, int is_br, int rd, int s1v, int s1,
                              int br_v, int br_hit, int wk_v, int wk, int rdy,
                              int exp_iv, int exp_rd, int exp_cnt);
      vec_t t;
      t.in_v = in_v; t.is_br = is_br; t.rd = rd; t.s1v = s1v; t.s1 = s1;
      t.br_v = br_v; t.br_hit = br_hit; t.wk_v = wk_v; t.wk = wk; t.rdy = rdy;
      t.exp_iv = exp_iv; t.exp_rd = exp_rd; t.exp_cnt = exp_cnt;
      return t;
   endfunction

   task automatic drive(input rinstr_t r, input br_result_t b, input p_reg_t w, input logic rdy);
      bus.rinstr_i      = r;
      bus.br_result_i   = b;
      bus.wakeup_i      = w;
      bus.issue_ready_i = rdy;
   endtask

   // Compare this cycle's outputs with the model, then advance the model
   task automatic model_step();
      int      sel;
      logic    exp_v, mis, was_full, new_spec;
      m_ent_t  nq[$];
      m_ent_t  e;
      sel = -1;
      for (int k = 0; k < m_q.size(); k++)
         if (m_q[k].tag == m_hold_tag) sel = k;
      if (sel < 0)
         for (int k = m_q.size() - 1; k >= 0; k--)
            if (m_q[k].instr.rs1.ready && m_q[k].instr.rs2.ready) sel = k;
      mis   = bus.br_result_i.valid && !bus.br_result_i.hit;
      exp_v = (sel >= 0) ? !(mis && m_q[sel].spec) : 1'b0;
      chk("model_issue_valid", 64'(bus.issue_o.valid), 64'(exp_v));
      if (exp_v) chk("model_issue_instr", 64'(bus.issue_o), 64'(m_q[sel].instr));
      chk("model_count", 64'(bus.count_o), 64'(m_q.size()));
      chk("model_full", 64'(bus.iq_full_o), 64'(m_q.size() == DEPTH));
      was_full   = (m_q.size() == DEPTH);
      m_hold_tag = (exp_v && !bus.issue_ready_i) ? m_q[sel].tag : -1;
      for (int k = 0; k < m_q.size(); k++) begin
         e = m_q[k];
         if (!(exp_v && bus.issue_ready_i && k == sel) && !(mis && e.spec)) begin
            if (bus.br_result_i.valid) e.spec = 1'b0;
            if (bus.wakeup_i.valid) begin
               if (e.instr.rs1.valid && e.instr.rs1.idx == bus.wakeup_i.idx) e.instr.rs1.ready = 1'b1;
               if (e.instr.rs2.valid && e.instr.rs2.idx == bus.wakeup_i.idx) e.instr.rs2.ready = 1'b1;
            end
            nq.push_back(e);
         end
      end
      new_spec = m_spec_active && !bus.br_result_i.valid && !bus.rinstr_i.is_branch;
      if (bus.br_result_i.valid) m_spec_active = 1'b0;
      if (bus.rinstr_i.valid && !was_full && !mis) begin
         e.instr = bus.rinstr_i;
         if (!e.instr.rs1.valid || (bus.wakeup_i.valid && e.instr.rs1.idx == bus.wakeup_i.idx))
            e.instr.rs1.ready = 1'b1;
         if (!e.instr.rs2.valid || (bus.wakeup_i.valid && e.instr.rs2.idx == bus.wakeup_i.idx))
            e.instr.rs2.ready = 1'b1;
         e.spec = new_spec;
         e.tag  = m_next_tag;
         m_next_tag++;
         nq.push_back(e);
         if (bus.rinstr_i.is_branch) m_spec_active = 1'b1;
      end
      m_q = nq;
   endtask

   task automatic tick();
      @(negedge clk_i);
      model_step();
   endtask

   task automatic advance();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive('0, '0, '0, 1'b0);
      rst_i         = 1'b1;
      m_q           = {};
      m_spec_active = 1'b0;
      m_hold_tag    = -1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("rst_count", 64'(bus.count_o), 64'(0));
         chk("rst_full", 64'(bus.iq_full_o), 64'(0));
         chk("rst_issue_valid", 64'(bus.issue_o.valid), 64'(0));
         advance();
      end
      rst_i = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rinstr_t    r;
      br_result_t b;
      p_reg_t     w;

      m_hold_tag    = -1;
      m_spec_active = 1'b0;
      m_next_tag    = 0;

      //            in br rd s1v s1  bv bh wv wk rdy  iv rd cnt
      vecs[0]  = v(1, 0, 40, 1, 33, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[1]  = v(0, 0, 0, 0, 0, 0, 0, 1, 33, 1, 0, 0, 1);
      vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 40, 1);
      vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[4]  = v(1, 0, 41, 1, 33, 0, 0, 1, 33, 1, 0, 0, 0);
      vecs[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 41, 1);
      vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[7]  = v(1, 0, 42, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[8]  = v(1, 0, 43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[9]  = v(1, 0, 44, 0, 0, 0, 0, 0, 0, 0, 1, 43, 2);
      vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 43, 3);
      vecs[11] = v(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 1, 44, 2);
      vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 42, 1);
      vecs[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[14] = v(1, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[15] = v(1, 1, 51, 1, 20, 0, 0, 0, 0, 0, 1, 50, 1);
      vecs[16] = v(1, 0, 52, 0, 0, 0, 0, 0, 0, 0, 1, 50, 2);
      vecs[17] = v(1, 0, 53, 0, 0, 0, 0, 0, 0, 0, 1, 50, 3);
      vecs[18] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 50, 4);
      vecs[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 50, 2);
      vecs[20] = v(0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 1, 50, 2);
      vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 51, 1);
      vecs[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[23] = v(1, 0, 60, 1, 21, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[24] = v(1, 1, 61, 1, 22, 0, 0, 0, 0, 1, 0, 0, 1);
      vecs[25] = v(1, 0, 62, 1, 23, 0, 0, 0, 0, 1, 0, 0, 2);
      vecs[26] = v(1, 0, 63, 1, 24, 0, 0, 0, 0, 1, 0, 0, 3);
      vecs[27] = v(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 4);
      vecs[28] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4);
      vecs[29] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);

      drive('0, '0, '0, 1'b0);
      do_reset();

      // Directed table: readiness, bypass, age order, mispredict and hit
      for (int i = 0; i < NV; i++) begin
         r = mk(1'(vecs[i].in_v), 1'(vecs[i].is_br), 6'(vecs[i].rd),
                1'(vecs[i].s1v), 6'(vecs[i].s1), 1'b0, 1'b0, 6'd0, 1'b0);
         b.valid = 1'(vecs[i].br_v);
         b.hit   = 1'(vecs[i].br_hit);
         w.valid = 1'(vecs[i].wk_v);
         w.idx   = 6'(vecs[i].wk);
         drive(r, b, w, 1'(vecs[i].rdy));
         tick();
         chk($sformatf("vec%0d_issue_valid", i), 64'(bus.issue_o.valid), 64'(vecs[i].exp_iv));
         if (vecs[i].exp_iv != 0)
            chk($sformatf("vec%0d_issue_rd", i), 64'(bus.issue_o.rd), 64'(vecs[i].exp_rd));
         chk($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vecs[i].exp_cnt));
         advance();
      end

      // Full / backpressure
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         drive(mk(1'b1, 1'b0, 6'(k + 1), 1'b1, 6'(40 + k), 1'b0, 1'b0, 6'd0, 1'b0), '0, '0, 1'b1);
         tick();
         advance();
      end
      drive(mk(1'b1, 1'b0, 6'd9, 1'b1, 6'd50, 1'b0, 1'b0, 6'd0, 1'b0), '0, '0, 1'b1);
      tick();
      chk("full_flag", 64'(bus.iq_full_o), 64'(1));
      chk("full_count", 64'(bus.count_o), 64'(8));
      advance();
      w.valid = 1'b1;
      w.idx   = 6'd42;
      drive('0, '0, w, 1'b1);
      tick();
      chk("ninth_ignored_count", 64'(bus.count_o), 64'(8));
      advance();
      drive('0, '0, '0, 1'b1);
      tick();
      chk("wake2_issue_valid", 64'(bus.issue_o.valid), 64'(1));
      chk("wake2_issue_rd", 64'(bus.issue_o.rd), 64'(3));
      advance();
      drive('0, '0, '0, 1'b0);
      tick();
      chk("after_pop_count", 64'(bus.count_o), 64'(7));
      chk("after_pop_full", 64'(bus.iq_full_o), 64'(0));
      advance();

      // Reset asserted mid-operation clears state without a clock edge
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_count", 64'(bus.count_o), 64'(0));
      chk("async_rst_issue_valid", 64'(bus.issue_o.valid), 64'(0));
      do_reset();

      // Stall stability
      drive(mk(1'b1, 1'b0, 6'd30, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0), '0, '0, 1'b0);
      tick();
      advance();
      drive(mk(1'b1, 1'b0, 6'd31, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0), '0, '0, 1'b0);
      tick();
      advance();
      drive('0, '0, '0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall_issue_valid", 64'(bus.issue_o.valid), 64'(1));
         chk("stall_issue_rd", 64'(bus.issue_o.rd), 64'(30));
         chk("stall_count", 64'(bus.count_o), 64'(2));
         advance();
      end
      drive('0, '0, '0, 1'b1);
      tick();
      chk("release_rd", 64'(bus.issue_o.rd), 64'(30));
      advance();
      drive('0, '0, '0, 1'b0);
      tick();
      chk("single_pop_count", 64'(bus.count_o), 64'(1));
      chk("next_rd", 64'(bus.issue_o.rd), 64'(31));
      advance();

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         b = '0;
         if (m_spec_active && $urandom_range(0, 7) == 0) begin
            b.valid = 1'b1;
            b.hit   = 1'($urandom_range(0, 1));
         end
         r = mk($urandom_range(0, 9) < 7, 1'b0, 6'($urandom),
                $urandom_range(0, 4) != 0, 6'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
                $urandom_range(0, 4) != 0, 6'($urandom_range(0, 7)), $urandom_range(0, 9) < 3);
         if (!m_spec_active && !b.valid && $urandom_range(0, 5) == 0) r.is_branch = 1'b1;
         w.valid = $urandom_range(0, 9) < 4;
         w.idx   = 6'($urandom_range(0, 7));
         drive(r, b, w, $urandom_range(0, 9) < 6);
         tick();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
